cnt_monitor: RTL and testbench

Sequence checker that sits at the receiving end of the free-running 16-bit `cnt` bus. It samples the count every clock, verifies each value is exactly the previous value plus one (mod 2^16), and declares lock after a run of good increments. It reports every break in sequence while locked, keeping a saturating error count and a capture of the offending value for the status/LED logic.

---
 rtl/cnt_monitor_if.sv | 20 ++
 rtl/cnt_monitor.sv | 118 +++++++++++
 tb/tb_cnt_monitor.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_monitor_if.sv
// Bundle between a free-running count source and its sequence checker.
// master: drives cnt_in/clear, reads status; slave: the checker side.
interface cnt_monitor_if;
    logic [15:0] cnt_in;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] last_bad;

    modport master (
        output cnt_in, clear,
        input  locked, err_pulse, err_count, last_bad
    );

    modport slave (
        input  cnt_in, clear,
        output locked, err_pulse, err_count, last_bad
    );
endinterface

// File: rtl/cnt_monitor.sv
// Checks that cnt_in increments by one (mod 2^16) every clock, locks after
// LOCK_CNT good steps, and counts/captures sequence breaks while locked.
// Ports: clk, rst_n (async active-low), bus (slave: cnt_in, clear in;
// locked, err_pulse, err_count, last_bad out, all registered).
module cnt_monitor #(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    cnt_monitor_if.slave  bus
);
    localparam logic [7:0] LOCK_C   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_C = 8'(UNLOCK_CNT);

    typedef enum logic {ACQ, LOCKED} state_t;

    state_t      state, state_nx;
    logic [15:0] prev;
    logic        prev_vld;
    logic [7:0]  run, run_nx;
    logic [7:0]  miss, miss_nx;

    logic        match, miss_hit, count_err;
    logic [15:0] err_count_nx, last_bad_nx;

    logic        locked_q, err_pulse_q;
    logic [15:0] err_count_q, last_bad_q;

    // Equality is evaluated at 16 bits, so prev + 1 wraps 0xFFFF -> 0x0000.
    assign match    = prev_vld && (bus.cnt_in == prev + 16'd1);
    assign miss_hit = prev_vld && !match;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACQ;
            run      <= '0;
            miss     <= '0;
            prev     <= '0;
            prev_vld <= 1'b0;
        end else begin
            state    <= state_nx;
            run      <= run_nx;
            miss     <= miss_nx;
            prev     <= bus.cnt_in;
            prev_vld <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        run_nx   = run;
        miss_nx  = miss;
        unique case (state)
            ACQ: begin
                if (match) begin
                    run_nx = run + 8'd1;
                    if (run_nx == LOCK_C) begin
                        state_nx = LOCKED;
                        miss_nx  = '0;
                    end
                end else if (miss_hit) begin
                    run_nx = '0;
                end
            end
            LOCKED: begin
                if (match) begin
                    miss_nx = '0;
                end else if (miss_hit) begin
                    miss_nx = miss + 8'd1;
                    if (miss_nx == UNLOCK_C) begin
                        state_nx = ACQ;
                        run_nx   = '0;
                    end
                end
            end
            default: state_nx = ACQ;
        endcase
    end

    // Output logic: errors only count while locked; clear wins over update
    // but the pulse for a coincident error still fires.
    always_comb begin
        count_err    = (state == LOCKED) && miss_hit;
        err_count_nx = err_count_q;
        last_bad_nx  = last_bad_q;
        if (count_err) begin
            if (err_count_q != 16'hFFFF)
                err_count_nx = err_count_q + 16'd1;
            last_bad_nx = bus.cnt_in;
        end
        if (bus.clear) begin
            err_count_nx = '0;
            last_bad_nx  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            last_bad_q  <= '0;
        end else begin
            locked_q    <= (state_nx == LOCKED);
            err_pulse_q <= count_err;
            err_count_q <= err_count_nx;
            last_bad_q  <= last_bad_nx;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
    assign bus.last_bad  = last_bad_q;
endmodule

// File: tb/tb_cnt_monitor.sv
// Self-checking bench for cnt_monitor: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_cnt_monitor;
    localparam int LOCK   = 4;
    localparam int UNLOCK = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    cnt_monitor_if bus ();

    cnt_monitor #(
        .LOCK_CNT   (LOCK),
        .UNLOCK_CNT (UNLOCK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural model: a sample history and counters kept as plain ints.
    bit m_have;
    int m_prev, m_good, m_bad, m_err, m_last;
    bit m_locked, m_pulse;

    function automatic void model_reset();
        m_have = 0; m_prev = 0; m_good = 0; m_bad = 0;
        m_err = 0; m_last = 0; m_locked = 0; m_pulse = 0;
    endfunction

    function automatic void model_step(int v, bit c);
        bit ok, ng;
        ok = m_have && (v == ((m_prev + 1) % 65536));
        ng = m_have && !ok;
        m_pulse = m_locked && ng;
        if (m_pulse) begin
            if (m_err < 65535) m_err++;
            m_last = v;
        end
        if (c) begin
            m_err = 0;
            m_last = 0;
        end
        if (!m_locked) begin
            if (ok) begin
                m_good++;
                if (m_good == LOCK) begin
                    m_locked = 1;
                    m_bad = 0;
                end
            end else if (ng) m_good = 0;
        end else begin
            if (ok) m_bad = 0;
            else if (ng) begin
                m_bad++;
                if (m_bad == UNLOCK) begin
                    m_locked = 0;
                    m_good = 0;
                end
            end
        end
        m_prev = v;
        m_have = 1;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".locked"}, 32'(bus.locked), 32'(m_locked));
        chk({tag, ".pulse"}, 32'(bus.err_pulse), 32'(m_pulse));
        chk({tag, ".ecount"}, 32'(bus.err_count), 32'(m_err));
        chk({tag, ".lbad"}, 32'(bus.last_bad), 32'(m_last));
    endtask

    task automatic do_cycle(logic [15:0] v, logic c, string tag);
        @(negedge clk);
        bus.cnt_in = v;
        bus.clear = c;
        @(posedge clk);
        model_step(int'(v), c);
        #1;
        chk_model(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.locked", 32'(bus.locked), 0);
        chk("rst.pulse", 32'(bus.err_pulse), 0);
        chk("rst.ecount", 32'(bus.err_count), 0);
        chk("rst.lbad", 32'(bus.last_bad), 0);
    endtask

    typedef struct {
        logic [15:0] cnt;
        logic        clr;
        logic        lk;
        logic        pl;
        logic [15:0] ec;
        logic [15:0] lb;
    } vec_t;

    vec_t vt[$];

    task automatic add(logic [15:0] c, logic cl, logic lk, logic pl,
                       logic [15:0] ec, logic [15:0] lb);
        vec_t v;
        v = '{cnt: c, clr: cl, lk: lk, pl: pl, ec: ec, lb: lb};
        vt.push_back(v);
    endtask

    initial begin
        logic [15:0] cur, v;
        logic        c;
        int          r;

        bus.cnt_in = '0;
        bus.clear = 1'b0;
        model_reset();

        // Lock, stall, jump, clear-with-error, glitch-unlock, relock.
        add(16'h0000, 0, 0, 0, 16'd0, 16'h0000);
        add(16'h0001, 0, 0, 0, 16'd0, 16'h0000);
        add(16'h0002, 0, 0, 0, 16'd0, 16'h0000);
        add(16'h0003, 0, 0, 0, 16'd0, 16'h0000);
        add(16'h0004, 0, 1, 0, 16'd0, 16'h0000);
        add(16'h0005, 0, 1, 0, 16'd0, 16'h0000);
        add(16'h0006, 0, 1, 0, 16'd0, 16'h0000);
        add(16'h0006, 0, 1, 1, 16'd1, 16'h0006);
        add(16'h0007, 0, 1, 0, 16'd1, 16'h0006);
        add(16'h0050, 0, 1, 1, 16'd2, 16'h0050);
        add(16'h0051, 0, 1, 0, 16'd2, 16'h0050);
        add(16'h0099, 1, 1, 1, 16'd0, 16'h0000);
        add(16'h009A, 0, 1, 0, 16'd0, 16'h0000);
        add(16'h0300, 0, 1, 1, 16'd1, 16'h0300);
        add(16'h009C, 0, 0, 1, 16'd2, 16'h009C);
        add(16'h009D, 0, 0, 0, 16'd2, 16'h009C);
        add(16'h009E, 0, 0, 0, 16'd2, 16'h009C);
        add(16'h009F, 0, 0, 0, 16'd2, 16'h009C);
        add(16'h00A0, 0, 1, 0, 16'd2, 16'h009C);
        add(16'h00A1, 0, 1, 0, 16'd2, 16'h009C);

        do_reset();
        foreach (vt[i]) begin
            do_cycle(vt[i].cnt, vt[i].clr, "tbl");
            chk($sformatf("tbl%0d.locked", i), 32'(bus.locked), 32'(vt[i].lk));
            chk($sformatf("tbl%0d.pulse", i), 32'(bus.err_pulse), 32'(vt[i].pl));
            chk($sformatf("tbl%0d.ecount", i), 32'(bus.err_count), 32'(vt[i].ec));
            chk($sformatf("tbl%0d.lbad", i), 32'(bus.last_bad), 32'(vt[i].lb));
        end

        // Wrap 0xFFFF -> 0x0000 while locked is a match.
        do_reset();
        cur = 16'hFFFB;
        for (int i = 0; i < 9; i++) begin
            do_cycle(cur, 1'b0, "wrap");
            cur = cur + 16'd1;
        end
        chk("wrap.locked", 32'(bus.locked), 1);
        chk("wrap.ecount", 32'(bus.err_count), 0);

        // Single stall at 0x1234 is one error and no unlock; five in total.
        do_reset();
        for (int i = 0; i < 5; i++)
            do_cycle(16'h1230 + 16'(i), 1'b0, "stall");
        chk("stall.prelock", 32'(bus.locked), 1);
        do_cycle(16'h1234, 1'b0, "stall");
        do_cycle(16'h1235, 1'b0, "stall");
        chk("stall.ecount1", 32'(bus.err_count), 1);
        chk("stall.lbad", 32'(bus.last_bad), 32'h1234);
        chk("stall.locked", 32'(bus.locked), 1);
        cur = 16'h1235;
        for (int i = 0; i < 4; i++) begin
            do_cycle(cur, 1'b0, "stall");
            cur = cur + 16'd1;
            do_cycle(cur, 1'b0, "stall");
        end
        chk("stall.ecount5", 32'(bus.err_count), 5);
        chk("stall.locked5", 32'(bus.locked), 1);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.locked", 32'(bus.locked), 0);
        chk("arst.pulse", 32'(bus.err_pulse), 0);
        chk("arst.ecount", 32'(bus.err_count), 0);
        chk("arst.lbad", 32'(bus.last_bad), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_cycle(16'h0400 + 16'(i), 1'b0, "relock");
            chk($sformatf("relock%0d", i), 32'(bus.locked), (i >= 4) ? 1 : 0);
        end

        // Randomized traffic against the model.
        do_reset();
        cur = 16'(($urandom_range(0, 1) != 0) ? 16'hFFF0 : $urandom);
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            v = cur;
            if (r < 85) begin
                cur = cur + 16'd1;
            end else if (r < 90) begin
                // stall: resend the same value
            end else if (r < 95) begin
                cur = 16'($urandom);
                v = cur;
                cur = cur + 16'd1;
            end else begin
                v = 16'($urandom);
                cur = cur + 16'd1;
            end
            c = ($urandom_range(0, 39) == 0);
            do_cycle(v, c, "rnd");
            if (r < 85) v = v;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
